// File: rtl/alu_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// alu_arb_pkg
// Shared definitions for the two-port ALU arbiter: widths, the opcode
// enumeration, the result-buffer state type and helpers that classify
// opcodes by how they touch the Z/V/N flag register.
// ---------------------------------------------------------------------------
package alu_arb_pkg;

  localparam int DATA_W = 16;
  localparam int OP_W   = 4;

  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_XOR    = 4'h2,
    OP_RED    = 4'h3,
    OP_SLL    = 4'h4,
    OP_SRA    = 4'h5,
    OP_ROR    = 4'h6,
    OP_PADDSB = 4'h7,
    OP_LW     = 4'h8,
    OP_SW     = 4'h9,
    OP_LLB    = 4'hA,
    OP_LHB    = 4'hB
  } alu_op_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_t;

  // Opcodes 0xC..0xF have no defined operation.
  function automatic logic is_invalid_op(input logic [OP_W-1:0] op);
    return op >= 4'hC;
  endfunction

  function automatic logic writes_zvn(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic writes_z_only(input logic [OP_W-1:0] op);
    return (op == OP_XOR) || (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_arbiter_if
// Request and result handshake bundle of the ALU arbiter.
//   req_valid/req_ready      : per-port request handshake (bit i = port i)
//   req{0,1}_opcode/_a/_b    : per-port operation and operands
//   res_valid/res_ready      : result handshake
//   res_data/res_id/res_err  : buffered result, issuing port, invalid-op tag
// Modports: master = requesters + consumer side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface alu_arbiter_if;
  import alu_arb_pkg::*;

  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [OP_W-1:0]   req0_opcode;
  logic [OP_W-1:0]   req1_opcode;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req0_b;
  logic [DATA_W-1:0] req1_b;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_id;
  logic              res_err;

  modport master (
    output req_valid, req0_opcode, req1_opcode, req0_a, req1_a, req0_b, req1_b,
    output res_ready,
    input  req_ready, res_valid, res_data, res_id, res_err
  );

  modport slave (
    input  req_valid, req0_opcode, req1_opcode, req0_a, req1_a, req0_b, req1_b,
    input  res_ready,
    output req_ready, res_valid, res_data, res_id, res_err
  );

endinterface

// File: rtl/alu_arbiter_alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
// Purely combinational 16-bit ALU shared by both requesters.
//   ALU_In1, ALU_In2 : operands
//   Opcode           : operation select (0xC..0xF give 0)
//   ALU_Out          : result
//   Z_set/V_set/N_set: candidate flag values; the caller decides which land
// ---------------------------------------------------------------------------
module alu_core
  import alu_arb_pkg::*;
(
  input  logic [DATA_W-1:0] ALU_In1,
  input  logic [DATA_W-1:0] ALU_In2,
  input  logic [OP_W-1:0]   Opcode,
  output logic [DATA_W-1:0] ALU_Out,
  output logic              Z_set,
  output logic              V_set,
  output logic              N_set
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic              add_ovf;
  logic              sub_ovf;
  logic [9:0]        red;
  logic [DATA_W-1:0] paddsb;
  logic [4:0]        nib;

  // Four independent signed nibble adds, each saturating to 0x7/0x8.
  always_comb begin
    paddsb = '0;
    nib    = '0;
    for (int i = 0; i < 4; i++) begin
      nib = {ALU_In1[4*i+3], ALU_In1[4*i +: 4]} + {ALU_In2[4*i+3], ALU_In2[4*i +: 4]};
      if (nib[4] != nib[3]) paddsb[4*i +: 4] = nib[4] ? 4'h8 : 4'h7;
      else                  paddsb[4*i +: 4] = nib[3:0];
    end
  end

  // Main operation mux. N is suppressed on a saturated overflow so a
  // clamped result is reported through V alone.
  always_comb begin
    sum     = ALU_In1 + ALU_In2;
    diff    = ALU_In1 - ALU_In2;
    add_ovf = (ALU_In1[DATA_W-1] == ALU_In2[DATA_W-1]) && (sum[DATA_W-1]  != ALU_In1[DATA_W-1]);
    sub_ovf = (ALU_In1[DATA_W-1] != ALU_In2[DATA_W-1]) && (diff[DATA_W-1] != ALU_In1[DATA_W-1]);
    red     = 10'(ALU_In1[15:8]) + 10'(ALU_In1[7:0]) + 10'(ALU_In2[15:8]) + 10'(ALU_In2[7:0]);
    ALU_Out = '0;
    V_set   = 1'b0;
    case (Opcode)
      OP_ADD: begin
        V_set   = add_ovf;
        ALU_Out = add_ovf ? (ALU_In1[DATA_W-1] ? SAT_MIN : SAT_MAX) : sum;
      end
      OP_SUB: begin
        V_set   = sub_ovf;
        ALU_Out = sub_ovf ? (ALU_In1[DATA_W-1] ? SAT_MIN : SAT_MAX) : diff;
      end
      OP_XOR:    ALU_Out = ALU_In1 ^ ALU_In2;
      OP_RED:    ALU_Out = {6'b0, red};
      OP_SLL:    ALU_Out = ALU_In1 << ALU_In2[3:0];
      OP_SRA:    ALU_Out = $signed(ALU_In1) >>> ALU_In2[3:0];
      OP_ROR:    ALU_Out = (ALU_In1 >> ALU_In2[3:0]) | (ALU_In1 << (5'd16 - {1'b0, ALU_In2[3:0]}));
      OP_PADDSB: ALU_Out = paddsb;
      OP_LW,
      OP_SW:     ALU_Out = (ALU_In1 & 16'hFFFE) + (ALU_In2 << 1);
      OP_LLB:    ALU_Out = {ALU_In1[15:8], ALU_In2[7:0]};
      OP_LHB:    ALU_Out = {ALU_In2[7:0], ALU_In1[7:0]};
      default:   ALU_Out = '0;
    endcase
    Z_set = (ALU_Out == '0);
    N_set = ALU_Out[DATA_W-1] & ~V_set;
  end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Two-port arbiter/sequencer for the shared ALU. Picks at most one request
// per cycle, evaluates it on the single alu_core, stores the result in a
// one-entry buffer tagged with the issuing port, and owns the Z/V/N flags.
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus (slave)         : request and result handshakes
//   flag_z/flag_v/flag_n: architectural flag register
// Build option: define ALU_ARB_RR_EN for round-robin between the two ports;
// otherwise port 0 has fixed priority and no pointer exists.
// ---------------------------------------------------------------------------
module alu_arbiter
  import alu_arb_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus,
  output logic          flag_z,
  output logic          flag_v,
  output logic          flag_n
);

  arb_state_t        state_q, state_d;
  logic [1:0]        grant;
  logic              accept;
  logic              sel;
  logic              can_accept;
  logic [OP_W-1:0]   op_sel;
  logic [DATA_W-1:0] a_sel, b_sel;
  logic [DATA_W-1:0] alu_out;
  logic              z_set, v_set, n_set;
  logic [DATA_W-1:0] data_q;
  logic              id_q;
  logic              err_q;

`ifdef ALU_ARB_RR_EN
  logic              last_q;
`endif

  assign can_accept = (state_q == EMPTY) || bus.res_ready;

  // Grant selection; rst_n gates it so nothing is offered while in reset.
  always_comb begin
    grant = 2'b00;
    if (can_accept && rst_n) begin
      case (bus.req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
`ifdef ALU_ARB_RR_EN
        2'b11:   grant = last_q ? 2'b01 : 2'b10;
`else
        2'b11:   grant = 2'b01;
`endif
        default: grant = 2'b00;
      endcase
    end
  end

  assign bus.req_ready = grant;
  assign accept        = |grant;
  assign sel           = grant[1];
  assign op_sel        = sel ? bus.req1_opcode : bus.req0_opcode;
  assign a_sel         = sel ? bus.req1_a      : bus.req0_a;
  assign b_sel         = sel ? bus.req1_b      : bus.req0_b;

  alu_core u_alu (
    .ALU_In1 (a_sel),
    .ALU_In2 (b_sel),
    .Opcode  (op_sel),
    .ALU_Out (alu_out),
    .Z_set   (z_set),
    .V_set   (v_set),
    .N_set   (n_set)
  );

  // Buffer occupancy: an accept always leaves it full (overwrite on a
  // simultaneous drain); a drain with no accept empties it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL: begin
        if (accept)             state_d = FULL;
        else if (bus.res_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // State, result buffer and flag register all update on the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
      flag_z  <= 1'b0;
      flag_v  <= 1'b0;
      flag_n  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q <= alu_out;
        id_q   <= sel;
        err_q  <= is_invalid_op(op_sel);
        if (writes_zvn(op_sel)) begin
          flag_z <= z_set;
          flag_v <= v_set;
          flag_n <= n_set;
        end else if (writes_z_only(op_sel)) begin
          flag_z <= z_set;
        end
      end
    end
  end

`ifdef ALU_ARB_RR_EN
  // Remembers the last served port; starts at 1 so port 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_q <= 1'b1;
    else if (accept) last_q <= sel;
  end
`endif

  assign bus.res_valid = (state_q == FULL);
  assign bus.res_data  = data_q;
  assign bus.res_id    = id_q;
  assign bus.res_err   = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
// Scoreboard bench for alu_arbiter. A negedge monitor predicts each accepted
// operation with an independent model and queues it; results are popped and
// compared when the consumer handshake fires. Directed sections cover
// saturation, flag rules, backpressure, reset and arbitration order.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

  typedef struct {
    logic [15:0] data;
    logic        id;
    logic        err;
    logic [2:0]  flags;   // {z, v, n}
  } exp_t;

  logic clk;
  logic rst_n;
  logic flag_z, flag_v, flag_n;

  int checks;
  int errors;

  exp_t        sb[$];
  int          grant_log[$];
  logic [2:0]  mflags;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .flag_z (flag_z),
    .flag_v (flag_v),
    .flag_n (flag_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Reference model built from signed integer arithmetic and range tests.
  function automatic exp_t predict(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                   input logic id, input logic [2:0] flags_in);
    exp_t e;
    int   t;
    logic v;
    e.id    = id;
    e.err   = (op >= 4'hC);
    e.flags = flags_in;
    e.data  = 16'h0000;
    t       = 0;
    v       = 1'b0;
    case (op)
      4'h0, 4'h1: begin
        if (op == 4'h0) t = $signed(a) + $signed(b);
        else            t = $signed(a) - $signed(b);
        if (t > 32767)       begin e.data = 16'h7FFF; v = 1'b1; end
        else if (t < -32768) begin e.data = 16'h8000; v = 1'b1; end
        else                 e.data = t[15:0];
        e.flags = {(e.data == 16'h0000), v, e.data[15] & ~v};
      end
      4'h2: begin
        e.data     = a ^ b;
        e.flags[2] = (e.data == 16'h0000);
      end
      4'h4: begin
        e.data     = a << b[3:0];
        e.flags[2] = (e.data == 16'h0000);
      end
      4'h8, 4'h9: e.data = (a & 16'hFFFE) + (b << 1);
      default:    e.data = 16'h0000;
    endcase
    return e;
  endfunction

  // Monitor: pop-and-compare the buffered result on a consumer handshake,
  // then predict and queue any request accepted in the same cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      grant_log.delete();
      mflags = 3'b000;
    end else begin
      checkOutput("ready_onehot", 32'($onehot0(bus.req_ready)), 32'd1);
      checkOutput("ready_no_valid", 32'(bus.req_ready & ~bus.req_valid), 32'd0);
      if (bus.res_valid && bus.res_ready) begin
        if (sb.size() == 0) begin
          checkOutput("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          checkOutput("res_data", 32'(bus.res_data), 32'(e.data));
          checkOutput("res_id", 32'(bus.res_id), 32'(e.id));
          checkOutput("res_err", 32'(bus.res_err), 32'(e.err));
          checkOutput("flags_zvn", 32'({flag_z, flag_v, flag_n}), 32'(e.flags));
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (bus.req_valid[p] && bus.req_ready[p]) begin
          if (p == 1) e = predict(bus.req1_opcode, bus.req1_a, bus.req1_b, 1'b1, mflags);
          else        e = predict(bus.req0_opcode, bus.req0_a, bus.req0_b, 1'b0, mflags);
          mflags = e.flags;
          sb.push_back(e);
          grant_log.push_back(p);
        end
      end
    end
  end

  task automatic setPort(input int port, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    if (port == 1) begin
      bus.req1_opcode = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_opcode = op; bus.req0_a = a; bus.req0_b = b;
    end
  endtask

  // Issue one request on a port and hold it until accepted (bounded).
  // Entered and left at posedge+1.
  task automatic applyStimulus(input int port, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic got;
    got = 1'b0;
    setPort(port, op, a, b);
    bus.req_valid[port] = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      got = bus.req_ready[port];
      @(posedge clk);
      #1;
    end
    bus.req_valid[port] = 1'b0;
    checkOutput("handshake", 32'(got), 32'd1);
  endtask

  // Drop each port's valid once it has transferred; all must finish.
  task automatic runBoth();
    logic [1:0] r;
    for (int c = 0; c < 20 && bus.req_valid != 2'b00; c++) begin
      @(negedge clk);
      r = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      if (r != 2'b00) checkOutput("overwrite_valid", 32'(bus.res_valid), 32'd1);
      bus.req_valid = bus.req_valid & ~r;
    end
    checkOutput("both_drained", 32'(bus.req_valid), 32'd0);
    bus.req_valid = 2'b00;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.req_valid = 2'b11;
    bus.res_ready = 1'b0;
    setPort(0, 4'h0, 16'h0001, 16'h0001);
    setPort(1, 4'h0, 16'h0002, 16'h0002);

    // Reset values and no grants while reset is held.
    #12;
    checkOutput("rst_res_valid", 32'(bus.res_valid), 32'd0);
    checkOutput("rst_res_data", 32'(bus.res_data), 32'd0);
    checkOutput("rst_res_id", 32'(bus.res_id), 32'd0);
    checkOutput("rst_res_err", 32'(bus.res_err), 32'd0);
    checkOutput("rst_flags", 32'({flag_z, flag_v, flag_n}), 32'd0);
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
    bus.req_valid = 2'b00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.res_ready = 1'b1;

    // Saturating ADD: result visible right after the accept edge.
    applyStimulus(0, 4'h0, 16'h7FFF, 16'h0001);
    checkOutput("sat_valid", 32'(bus.res_valid), 32'd1);
    checkOutput("sat_data", 32'(bus.res_data), 32'h7FFF);
    checkOutput("sat_id", 32'(bus.res_id), 32'd0);
    checkOutput("sat_flags", 32'({flag_z, flag_v, flag_n}), 32'b010);

    // SUB saturating low, then XOR touches Z only.
    applyStimulus(1, 4'h1, 16'h8000, 16'h0001);
    checkOutput("sub_data", 32'(bus.res_data), 32'h8000);
    checkOutput("sub_flags", 32'({flag_z, flag_v, flag_n}), 32'b010);
    applyStimulus(0, 4'h2, 16'h00FF, 16'h00FF);
    checkOutput("xor_data", 32'(bus.res_data), 32'h0000);
    checkOutput("xor_flags", 32'({flag_z, flag_v, flag_n}), 32'b110);

    // Invalid opcode and LW leave flags alone.
    applyStimulus(1, 4'hD, 16'h1234, 16'h5678);
    checkOutput("inv_err", 32'(bus.res_err), 32'd1);
    checkOutput("inv_data", 32'(bus.res_data), 32'h0000);
    checkOutput("inv_flags", 32'({flag_z, flag_v, flag_n}), 32'b110);
    applyStimulus(0, 4'h8, 16'h1001, 16'h0004);
    checkOutput("lw_data", 32'(bus.res_data), 32'h1008);
    checkOutput("lw_err", 32'(bus.res_err), 32'd0);
    checkOutput("lw_flags", 32'({flag_z, flag_v, flag_n}), 32'b110);

    // Shift clears Z; a normal negative ADD sets N.
    applyStimulus(1, 4'h4, 16'h0003, 16'h0004);
    checkOutput("sll_flags", 32'({flag_z, flag_v, flag_n}), 32'b010);
    applyStimulus(0, 4'h0, 16'h0005, 16'hFFF0);
    checkOutput("addneg_data", 32'(bus.res_data), 32'hFFF5);
    checkOutput("addneg_flags", 32'({flag_z, flag_v, flag_n}), 32'b001);

    // Backpressure: buffer full with res_ready low blocks both ports.
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    applyStimulus(0, 4'h0, 16'h0005, 16'h0006);
    setPort(0, 4'h1, 16'h000A, 16'h0003);
    setPort(1, 4'h2, 16'h0F0F, 16'h00FF);
    bus.req_valid = 2'b11;
    repeat (3) begin
      @(negedge clk);
      checkOutput("bp_ready", 32'(bus.req_ready), 32'd0);
      checkOutput("bp_hold", 32'(bus.res_data), 32'h000B);
      checkOutput("bp_valid", 32'(bus.res_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    bus.res_ready = 1'b1;
    runBoth();

    // Asynchronous reset while full, then arbitration order from reset.
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    applyStimulus(0, 4'h0, 16'h8000, 16'h8000);
    checkOutput("pre_rst_flags", 32'({flag_z, flag_v, flag_n}), 32'b010);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", 32'(bus.res_valid), 32'd0);
    checkOutput("arst_data", 32'(bus.res_data), 32'd0);
    checkOutput("arst_flags", 32'({flag_z, flag_v, flag_n}), 32'd0);
    setPort(0, 4'h0, 16'h0001, 16'h0001);
    setPort(1, 4'h1, 16'h0009, 16'h0002);
    bus.req_valid = 2'b11;
    #1;
    checkOutput("arst_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    bus.req_valid = 2'b00;
    checkOutput("grant_count", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
`ifdef ALU_ARB_RR_EN
      checkOutput("grant_order", 32'(grant_log[i]), 32'(i % 2));
`else
      checkOutput("grant_order", 32'(grant_log[i]), 32'd0);
`endif
    end

    // Drain with no new accepts empties the buffer.
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("final_valid", 32'(bus.res_valid), 32'd0);
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
